fir_param_cfg: RTL

- Parametrised direct-form FIR filter with run-time loadable signed coefficients.
- Generalises the fixed 8-tap, 6-bit filter: configurable data, coefficient, output width and tap count; single clock edge; explicit output-valid handshake; coefficient-load counter.
- Sits between the sample source and the output pins. A coefficient-load mode shares the input path with sample streaming.

---
 rtl/fir_param_cfg.sv | 106 ++++++++++
 1 files changed

// File: rtl/fir_param_cfg.sv
// Parametrised direct-form FIR with shift-loaded signed coefficients and an IDLE/RUN/CONFIG controller.
// Optional output saturation is enabled by defining FIR_PARAM_SAT_EN; by default the result wraps.
//
// state  | meaning
// IDLE   | no sample accepted last cycle, not loading coefficients
// RUN    | streaming samples
// CONFIG | cfg_load seen last cycle; coefficients shifting in, samples dropped
module fir_param_cfg #(
  parameter int DATA_W = 6,
  parameter int COEF_W = 2,
  parameter int TAPS   = 8,
  parameter int OUT_W  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     cfg_load,
  input  logic signed [COEF_W-1:0] cfg_coef,
  output logic                     out_valid,
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     cfg_full,
  output logic                     busy_cfg
);

  localparam int ACC_W  = DATA_W + COEF_W + $clog2(TAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int CNT_W  = $clog2(TAPS + 1);

  typedef enum logic [1:0] {IDLE, RUN, CONFIG} state_t;

  state_t                    state;
  logic signed [DATA_W-1:0]  dline     [TAPS];
  logic signed [DATA_W-1:0]  dline_nxt [TAPS];
  logic signed [COEF_W-1:0]  tap       [TAPS];
  logic signed [PROD_W-1:0]  prod      [TAPS];
  logic        [CNT_W-1:0]   cnt;
  logic signed [ACC_W-1:0]   acc;
  logic signed [OUT_W-1:0]   result;

  // The sum covers the line as it will be after this cycle's shift, so the new sample contributes.
  always_comb begin
    dline_nxt[0] = in_data;
    for (int i = 1; i < TAPS; i++) dline_nxt[i] = dline[i-1];
    acc = '0;
    for (int i = 0; i < TAPS; i++) begin
      prod[i] = PROD_W'(dline_nxt[i]) * PROD_W'(tap[i]);
      acc     = acc + ACC_W'(prod[i]);
    end
  end

`ifdef FIR_PARAM_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  always_comb begin
    if (acc > SAT_MAX)      result = SAT_MAX[OUT_W-1:0];
    else if (acc < SAT_MIN) result = SAT_MIN[OUT_W-1:0];
    else                    result = acc[OUT_W-1:0];
  end
`else
  logic unused_acc;

  assign result     = acc[OUT_W-1:0];
  assign unused_acc = ^acc;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      for (int i = 0; i < TAPS; i++) begin
        dline[i] <= '0;
        tap[i]   <= (i % 2 == 0) ? COEF_W'(1) : '0;
      end
    end else begin
      out_valid <= 1'b0;
      if (cfg_load) begin
        state  <= CONFIG;
        tap[0] <= cfg_coef;
        for (int i = 1; i < TAPS; i++) tap[i] <= tap[i-1];
        for (int i = 0; i < TAPS; i++) dline[i] <= '0;
        // Entering CONFIG restarts the count; this cycle's coefficient is the first one.
        if (state != CONFIG)          cnt <= CNT_W'(1);
        else if (cnt != CNT_W'(TAPS)) cnt <= cnt + CNT_W'(1);
      end else begin
        if (in_valid) begin
          dline     <= dline_nxt;
          out_valid <= 1'b1;
          out_data  <= result;
        end
        case (state)
          IDLE:    state <= in_valid ? RUN : IDLE;
          RUN:     state <= in_valid ? RUN : IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign cfg_full = (cnt == CNT_W'(TAPS));
  assign busy_cfg = (state == CONFIG);

endmodule
